lsu_mem_ctrl: RTL and testbench

// Load/store unit controller downstream of dispatch. Takes one decoded memory op (address, byte mask,

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Latched memory op held for the lifetime of one transaction
  typedef struct packed {
    logic            is_store;
    logic [2:0]      ltype;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      ltype_i,
  output logic [XLEN-1:0] data_c_o
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  always_comb begin
    byte_sh  = rdata_i >> {offset_i, 3'b000};
    half_sh  = rdata_i >> {offset_i[1], 4'b0000};
    data_c_o = rdata_i;
    case (ltype_i)
      LT_LB:   data_c_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LT_LH:   data_c_o = {{16{half_sh[15]}}, half_sh[15:0]};
      LT_LBU:  data_c_o = {24'h0, byte_sh[7:0]};
      LT_LHU:  data_c_o = {16'h0, half_sh[15:0]};
      default: data_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding LSU controller: dispatch handshake, data-bus req/gnt/rvalid,
// load alignment, write-back and access-fault reporting with response timeout.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_load_i,
  input  logic                  req_store_i,
  input  logic [2:0]            req_ltype_i,
  input  logic [31:0]           req_addr_i,
  input  logic [3:0]            req_wmask_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [REG_ADDR_W-1:0] req_rd_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic                  store_done_o,
  output logic                  fault_load_o,
  output logic                  fault_store_o,
  output logic [31:0]           fault_addr_o,
  output logic                  busy_o
);

  localparam int unsigned    CntW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q, state_d;
  lsu_req_t              req_q, req_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  discard_q, discard_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [31:0]           fault_addr_q, fault_addr_d;
  logic                  store_done_q, store_done_d;
  logic                  fault_load_q, fault_load_d;
  logic                  fault_store_q, fault_store_d;
  logic                  req_ready_q, mem_req_q, busy_q, wb_valid_q;
  logic                  drop_c;
  logic [31:0]           align_data_c;

  lsu_load_align u_align (
    .rdata_i  (mem_rdata_i),
    .offset_i (req_q.addr[1:0]),
    .ltype_i  (req_q.ltype),
    .data_c_o (align_data_c)
  );

  // A flush arriving in the same cycle as the response still squashes it
  assign drop_c = discard_q | flush_i;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    rd_d          = rd_q;
    discard_d     = discard_q;
    cnt_d         = cnt_q;
    wb_data_d     = wb_data_q;
    fault_addr_d  = fault_addr_q;
    store_done_d  = 1'b0;
    fault_load_d  = 1'b0;
    fault_store_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && (req_load_i || req_store_i) && !flush_i) begin
          req_d.is_store = req_store_i;
          req_d.ltype    = req_ltype_i;
          req_d.addr     = req_addr_i;
          req_d.be       = req_store_i ? req_wmask_i : 4'hF;
          req_d.wdata    = req_wdata_i;
          rd_d           = req_rd_i;
          discard_d      = 1'b0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          state_d   = WAIT;
          cnt_d     = '0;
          discard_d = flush_i;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (!drop_c) begin
            if (mem_err_i) begin
              fault_load_d  = !req_q.is_store;
              fault_store_d = req_q.is_store;
              fault_addr_d  = req_q.addr;
            end else if (req_q.is_store) begin
              store_done_d = 1'b1;
            end else begin
              wb_data_d = align_data_c;
              state_d   = WB;
            end
          end
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          if (!drop_c) begin
            fault_load_d  = !req_q.is_store;
            fault_store_d = req_q.is_store;
            fault_addr_d  = req_q.addr;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (flush_i) discard_d = 1'b1;
        end
      end
      WB: begin
        if (wb_ready_i || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with state_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_q         <= '0;
      rd_q          <= '0;
      discard_q     <= 1'b0;
      cnt_q         <= '0;
      wb_data_q     <= '0;
      fault_addr_q  <= '0;
      store_done_q  <= 1'b0;
      fault_load_q  <= 1'b0;
      fault_store_q <= 1'b0;
      req_ready_q   <= 1'b1;
      mem_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      rd_q          <= rd_d;
      discard_q     <= discard_d;
      cnt_q         <= cnt_d;
      wb_data_q     <= wb_data_d;
      fault_addr_q  <= fault_addr_d;
      store_done_q  <= store_done_d;
      fault_load_q  <= fault_load_d;
      fault_store_q <= fault_store_d;
      req_ready_q   <= (state_d == IDLE);
      mem_req_q     <= (state_d == ISSUE);
      busy_q        <= (state_d != IDLE);
      wb_valid_q    <= (state_d == WB);
    end
  end

  assign req_ready_o   = req_ready_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = req_q.is_store;
  assign mem_addr_o    = {req_q.addr[31:2], 2'b00};
  assign mem_be_o      = req_q.be;
  assign mem_wdata_o   = req_q.wdata;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_o       = rd_q;
  assign wb_data_o     = wb_data_q;
  assign store_done_o  = store_done_q;
  assign fault_load_o  = fault_load_q;
  assign fault_store_o = fault_store_q;
  assign fault_addr_o  = fault_addr_q;
  assign busy_o        = busy_q;

`ifndef SYNTHESIS
  a_no_ld_st: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_valid_i && req_load_i && req_store_i))
    else $error("lsu_mem_ctrl: load and store offered together");
  a_lw_align: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid_i && req_load_i && (req_ltype_i == LT_LW)) |-> (req_addr_i[1:0] == 2'b00))
    else $error("lsu_mem_ctrl: misaligned word load");
  a_lh_align: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid_i && req_load_i && ((req_ltype_i == LT_LH) || (req_ltype_i == LT_LHU)))
      |-> !req_addr_i[0])
    else $error("lsu_mem_ctrl: misaligned half load");
  a_rvalid_wait: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid_i |-> (state_q == WAIT))
    else $warning("lsu_mem_ctrl: mem_rvalid_i outside WAIT ignored");
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: load extraction, stalls, faults, flush and reset recovery.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_load_i, req_store_i;
  logic [2:0]  req_ltype_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wmask_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i, mem_err_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o, fault_addr_o;
  logic        store_done_o, fault_load_o, fault_store_o, busy_o;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0]  LD_TYPE [6] = '{LT_LHU, LT_LW, LT_LH, LT_LBU, LT_LH, LT_LB};
  localparam logic [31:0] LD_ADDR [6] = '{32'h2002, 32'h2004, 32'h2002, 32'h2001, 32'h2000, 32'h2000};
  localparam logic [31:0] LD_DATA [6] = '{32'h8001_1234, 32'hDEAD_BEEF, 32'h8001_1234,
                                          32'h1234_F6AB, 32'h0001_7FFE, 32'h0000_007F};
  localparam logic [31:0] LD_EXP  [6] = '{32'h0000_8001, 32'hDEAD_BEEF, 32'hFFFF_8001,
                                          32'h0000_00F6, 32'h0000_7FFE, 32'h0000_007F};

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(256), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_load_i(req_load_i), .req_store_i(req_store_i), .req_ltype_i(req_ltype_i),
    .req_addr_i(req_addr_i), .req_wmask_i(req_wmask_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .store_done_o(store_done_o), .fault_load_o(fault_load_o), .fault_store_o(fault_store_o),
    .fault_addr_o(fault_addr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single cycle; returns in the first cycle after acceptance
  task automatic accept(input logic ld, input logic [2:0] lt, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d, input logic [4:0] rd);
    req_valid_i = 1'b1; req_load_i = ld; req_store_i = !ld; req_ltype_i = lt;
    req_addr_i = a; req_wmask_i = m; req_wdata_i = d; req_rd_i = rd;
    step();
    req_valid_i = 1'b0; req_load_i = 1'b0; req_store_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic err);
    mem_rvalid_i = 1'b1; mem_rdata_i = d; mem_err_i = err;
    step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
    checks++;
    if ({mem_req_o, busy_o, wb_valid_o, store_done_o, fault_load_o, fault_store_o, mem_we_o} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000000",
        {mem_req_o, busy_o, wb_valid_o, store_done_o, fault_load_o, fault_store_o, mem_we_o});
    end
    checks++;
    if ({mem_addr_o, wb_data_o, fault_addr_o, mem_be_o} !== 100'h0) begin
      errors++; $display("FAIL reset_data: addr %h wb %h faddr %h be %b want 0",
        mem_addr_o, wb_data_o, fault_addr_o, mem_be_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lb_latency();
    accept(1'b1, LT_LB, 32'h1003, 4'h0, 32'h0, 5'd9);
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, req_ready_o} !== {1'b1, 1'b0, 4'hF, 32'h1000, 1'b0}) begin
      errors++; $display("FAIL lb_issue: req %b we %b be %b addr %h rdy %b want 1 0 1111 00001000 0",
        mem_req_o, mem_we_o, mem_be_o, mem_addr_o, req_ready_o);
    end
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    checks++;
    if ({mem_req_o, wb_valid_o} !== 2'b00) begin
      errors++; $display("FAIL lb_wait: req %b wbv %b want 0 0", mem_req_o, wb_valid_o);
    end
    respond(32'h80AA_BBCC, 1'b0);
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd9, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL lb_wb: valid %b rd %0d data %h want 1 9 ffffff80", wb_valid_o, wb_rd_o, wb_data_o);
    end
    wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
    checks++;
    if ({wb_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL lb_release: wbv %b rdy %b want 0 1", wb_valid_o, req_ready_o);
    end
  endtask

  task automatic test_load_types();
    for (int i = 0; i < 6; i++) begin
      accept(1'b1, LD_TYPE[i], LD_ADDR[i], 4'h0, 32'h0, 5'(10 + i));
      mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
      respond(LD_DATA[i], 1'b0);
      checks++;
      if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'(10 + i), LD_EXP[i]}) begin
        errors++; $display("FAIL load_type_%0d: valid %b rd %0d data %h want 1 %0d %h",
          i, wb_valid_o, wb_rd_o, wb_data_o, 10 + i, LD_EXP[i]);
      end
      repeat (5) step();
      checks++;
      if ({wb_valid_o, wb_data_o, busy_o} !== {1'b1, LD_EXP[i], 1'b1}) begin
        errors++; $display("FAIL load_hold_%0d: valid %b data %h busy %b want 1 %h 1",
          i, wb_valid_o, wb_data_o, busy_o, LD_EXP[i]);
      end
      wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
    end
  endtask

  task automatic test_store_gnt_delay();
    accept(1'b0, LT_LB, 32'h3001, 4'b0010, 32'h0000_5A00, 5'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
          {1'b1, 1'b1, 4'b0010, 32'h3000, 32'h0000_5A00}) begin
        errors++; $display("FAIL store_hold_%0d: req %b we %b be %b addr %h wdata %h want 1 1 0010 00003000 00005a00",
          i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      step();
    end
    mem_gnt_i = 1'b1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++; $display("FAIL store_req4: got %b want 1", mem_req_o);
    end
    step(); mem_gnt_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++; $display("FAIL store_req_drop: got %b want 0", mem_req_o);
    end
    respond(32'h0, 1'b0);
    checks++;
    if ({store_done_o, fault_store_o} !== 2'b10) begin
      errors++; $display("FAIL store_done: done %b fault %b want 1 0", store_done_o, fault_store_o);
    end
    step();
    checks++;
    if ({store_done_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL store_pulse: done %b rdy %b want 0 1", store_done_o, req_ready_o);
    end
  endtask

  task automatic test_bus_error();
    accept(1'b0, LT_LB, 32'h5004, 4'hF, 32'h1111_2222, 5'd0);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    respond(32'h0, 1'b1);
    checks++;
    if ({fault_store_o, fault_load_o, store_done_o, fault_addr_o} !== {3'b100, 32'h5004}) begin
      errors++; $display("FAIL store_err: fs %b fl %b done %b faddr %h want 1 0 0 00005004",
        fault_store_o, fault_load_o, store_done_o, fault_addr_o);
    end
    accept(1'b1, LT_LB, 32'h5009, 4'h0, 32'h0, 5'd2);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    respond(32'hFFFF_FFFF, 1'b1);
    checks++;
    if ({fault_load_o, fault_store_o, wb_valid_o, fault_addr_o} !== {3'b100, 32'h5009}) begin
      errors++; $display("FAIL load_err: fl %b fs %b wbv %b faddr %h want 1 0 0 00005009",
        fault_load_o, fault_store_o, wb_valid_o, fault_addr_o);
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    accept(1'b1, LT_LW, 32'h4008, 4'h0, 32'h0, 5'd4);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      step();
      if (fault_load_o) begin seen = 1'b1; n = i; end
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL timeout_cycles: fault after %0d cycles want 256", n);
    end
    checks++;
    if ({fault_addr_o, fault_store_o, wb_valid_o} !== {32'h4008, 2'b00}) begin
      errors++; $display("FAIL timeout_addr: faddr %h fs %b wbv %b want 00004008 0 0",
        fault_addr_o, fault_store_o, wb_valid_o);
    end
    step();
    checks++;
    if ({fault_load_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL timeout_pulse: fl %b rdy %b want 0 1", fault_load_o, req_ready_o);
    end
  endtask

  task automatic test_flush();
    accept(1'b1, LT_LW, 32'h8000, 4'h0, 32'h0, 5'd5);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    checks++;
    if ({mem_req_o, busy_o, req_ready_o} !== 3'b001) begin
      errors++; $display("FAIL flush_issue: req %b busy %b rdy %b want 0 0 1", mem_req_o, busy_o, req_ready_o);
    end
    accept(1'b1, LT_LW, 32'h8004, 4'h0, 32'h0, 5'd6);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    respond(32'h1234_5678, 1'b0);
    checks++;
    if ({wb_valid_o, fault_load_o, store_done_o, req_ready_o} !== 4'b0001) begin
      errors++; $display("FAIL flush_wait: wbv %b fl %b done %b rdy %b want 0 0 0 1",
        wb_valid_o, fault_load_o, store_done_o, req_ready_o);
    end
    accept(1'b0, LT_LB, 32'h8008, 4'hF, 32'h0, 5'd0);
    mem_gnt_i = 1'b1; flush_i = 1'b1; step(); mem_gnt_i = 1'b0; flush_i = 1'b0;
    respond(32'h0, 1'b1);
    checks++;
    if ({fault_store_o, store_done_o, req_ready_o} !== 3'b001) begin
      errors++; $display("FAIL flush_gnt: fs %b done %b rdy %b want 0 0 1", fault_store_o, store_done_o, req_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    accept(1'b0, LT_LB, 32'h7000, 4'hF, 32'h1122_3344, 5'd0);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    respond(32'h0, 1'b0);
    checks++;
    if ({store_done_o, req_ready_o} !== 2'b11) begin
      errors++; $display("FAIL b2b_done: done %b rdy %b want 1 1", store_done_o, req_ready_o);
    end
    accept(1'b1, LT_LW, 32'h7004, 4'h0, 32'h0, 5'd7);
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h7004}) begin
      errors++; $display("FAIL b2b_issue: req %b we %b addr %h want 1 0 00007004", mem_req_o, mem_we_o, mem_addr_o);
    end
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    respond(32'hCAFE_F00D, 1'b0);
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd7, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL b2b_wb: valid %b rd %0d data %h want 1 7 cafef00d", wb_valid_o, wb_rd_o, wb_data_o);
    end
    flush_i = 1'b1; step(); flush_i = 1'b0;
    checks++;
    if ({wb_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL wb_flush: wbv %b rdy %b want 0 1", wb_valid_o, req_ready_o);
    end
    req_valid_i = 1'b1; step(); req_valid_i = 1'b0;
    checks++;
    if ({mem_req_o, busy_o, req_ready_o} !== 3'b001) begin
      errors++; $display("FAIL noop_drop: req %b busy %b rdy %b want 0 0 1", mem_req_o, busy_o, req_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    accept(1'b1, LT_LW, 32'h6000, 4'h0, 32'h0, 5'd3);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    rst_n = 1'b0; step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; step();
    mem_rvalid_i = 1'b0; rst_n = 1'b1;
    step();
    checks++;
    if ({wb_valid_o, busy_o, fault_load_o, req_ready_o, wb_data_o} !== {4'b0001, 32'h0}) begin
      errors++; $display("FAIL reset_mid: wbv %b busy %b fl %b rdy %b data %h want 0 0 0 1 0",
        wb_valid_o, busy_o, fault_load_o, req_ready_o, wb_data_o);
    end
    accept(1'b1, LT_LW, 32'h6004, 4'h0, 32'h0, 5'd8);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    respond(32'h0123_4567, 1'b0);
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd8, 32'h0123_4567}) begin
      errors++; $display("FAIL reset_recover: valid %b rd %0d data %h want 1 8 01234567", wb_valid_o, wb_rd_o, wb_data_o);
    end
    wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_load_i = 1'b0; req_store_i = 1'b0;
    req_ltype_i = 3'b0; req_addr_i = 32'h0; req_wmask_i = 4'h0; req_wdata_i = 32'h0;
    req_rd_i = 5'd0; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0; mem_err_i = 1'b0; wb_ready_i = 1'b0;
    test_reset();
    test_lb_latency();
    test_load_types();
    test_store_gnt_delay();
    test_bus_error();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
